// File: rtl/mux_scan_if.sv
// Bus between the scan sequencer and a 74LS153-style dual 4-to-1 mux.
// master: the sequencer side. slave: the mux/environment side.
interface mux_scan_if;
    logic       start;
    logic       Y1;
    logic       Y2;
    logic       A1;
    logic       A0;
    logic       S1_n;
    logic       S2_n;
    logic [3:0] D1_word;
    logic [3:0] D2_word;
    logic       busy;
    logic       done;

    modport master (
        input  start, Y1, Y2,
        output A1, A0, S1_n, S2_n, D1_word, D2_word, busy, done
    );

    modport slave (
        output start, Y1, Y2,
        input  A1, A0, S1_n, S2_n, D1_word, D2_word, busy, done
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a dual 4-to-1 mux: walks select codes 0..3, holds each
// code for SETTLE cycles, samples Y1/Y2, then publishes both 4-bit words
// with a one-cycle done pulse. All outputs are registered.
// Optional build macro MUX_SCAN_CONT_EN: scans repeat back-to-back forever
// after a single start, until rst.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst,
    mux_scan_if.master    bus
);
    // A SETTLE of 0 is treated as 1, so the terminal count is never negative.
    localparam logic [7:0] CNT_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] sel, sel_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] sh1, sh1_nxt, sh2, sh2_nxt;
    logic [1:0] a_q, a_nxt;
    logic       s_n_q, s_n_nxt;
    logic [3:0] d1_q, d1_nxt, d2_q, d2_nxt;
    logic       busy_q, busy_nxt;
    logic       done_q, done_nxt;

    // State and registered outputs; reset aborts any scan and clears the words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sel    <= 2'd0;
            cnt    <= 8'd0;
            sh1    <= 4'd0;
            sh2    <= 4'd0;
            a_q    <= 2'd0;
            s_n_q  <= 1'b1;
            d1_q   <= 4'd0;
            d2_q   <= 4'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            cnt    <= cnt_nxt;
            sh1    <= sh1_nxt;
            sh2    <= sh2_nxt;
            a_q    <= a_nxt;
            s_n_q  <= s_n_nxt;
            d1_q   <= d1_nxt;
            d2_q   <= d2_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Next state and next output values; outputs are computed one cycle
    // ahead so they change only on clock edges and never glitch.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        sh1_nxt   = sh1;
        sh2_nxt   = sh2;
        a_nxt     = a_q;
        s_n_nxt   = s_n_q;
        d1_nxt    = d1_q;
        d2_nxt    = d2_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                a_nxt    = 2'd0;
                s_n_nxt  = 1'b1;
                busy_nxt = 1'b0;
                if (bus.start) begin
                    state_nxt = S_SETTLE;
                    sel_nxt   = 2'd0;
                    cnt_nxt   = 8'd0;
                    s_n_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            S_SETTLE: begin
                cnt_nxt = cnt + 8'd1;
                if (cnt == CNT_LAST) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                sh1_nxt[sel] = bus.Y1;
                sh2_nxt[sel] = bus.Y2;
                if (sel == 2'd3) begin
                    // Words load on the edge entering DONE so they are
                    // visible together with the done pulse; bit 3 comes
                    // straight from the mux since it is sampled this edge.
                    state_nxt = S_DONE;
                    d1_nxt    = {bus.Y1, sh1[2:0]};
                    d2_nxt    = {bus.Y2, sh2[2:0]};
                    done_nxt  = 1'b1;
                    a_nxt     = 2'd0;
`ifdef MUX_SCAN_CONT_EN
                    s_n_nxt   = 1'b0;
`else
                    s_n_nxt   = 1'b1;
`endif
                end else begin
                    state_nxt = S_SETTLE;
                    sel_nxt   = sel + 2'd1;
                    cnt_nxt   = 8'd0;
                    a_nxt     = sel + 2'd1;
                end
            end
            S_DONE: begin
                sel_nxt = 2'd0;
                cnt_nxt = 8'd0;
                a_nxt   = 2'd0;
`ifdef MUX_SCAN_CONT_EN
                state_nxt = S_SETTLE;
                s_n_nxt   = 1'b0;
                busy_nxt  = 1'b1;
`else
                state_nxt = S_IDLE;
                s_n_nxt   = 1'b1;
                busy_nxt  = 1'b0;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.A1      = a_q[1];
    assign bus.A0      = a_q[0];
    assign bus.S1_n    = s_n_q;
    assign bus.S2_n    = s_n_q;
    assign bus.D1_word = d1_q;
    assign bus.D2_word = d2_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench: three sequencers (SETTLE = 2, 1, 255) each driving a
// behavioural 74LS153 model; expected per-cycle outputs come from a
// cycle-index arithmetic model of one scan.
module tb_mux_scan_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_v [3];
    logic [3:0] d1_v    [3];
    logic [3:0] d2_v    [3];
    logic [5:0] out_v   [3];   // {A1,A0,S1_n,S2_n,busy,done}
    logic [3:0] w1_v    [3];
    logic [3:0] w2_v    [3];
    logic [3:0] prev1   [3];
    logic [3:0] prev2   [3];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mux_scan_if u_if ();
        mux_scan_sequencer #(.SETTLE(g == 0 ? 2 : (g == 1 ? 1 : 255))) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if.master)
        );
        // 74LS153 section: strobe high forces the output low.
        assign u_if.start = start_v[g];
        assign u_if.Y1    = u_if.S1_n ? 1'b0 : d1_v[g][{u_if.A1, u_if.A0}];
        assign u_if.Y2    = u_if.S2_n ? 1'b0 : d2_v[g][{u_if.A1, u_if.A0}];
        assign out_v[g]   = {u_if.A1, u_if.A0, u_if.S1_n, u_if.S2_n, u_if.busy, u_if.done};
        assign w1_v[g]    = u_if.D1_word;
        assign w2_v[g]    = u_if.D2_word;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected control outputs k cycles after the edge that sampled start.
    // Each select code owns s+1 cycles; one done cycle follows the scan.
    function automatic logic [5:0] exp_scan(input int s, input int k, input bit cont);
        int n = 4 * (s + 1);
        int p;
        p = cont ? (k - 1) % (n + 1) + 1 : k;
        if (p <= n)      return {2'((p - 1) / (s + 1)), 2'b00, 1'b1, 1'b0};
        else if (p == n + 1) return {2'b00, cont ? 2'b00 : 2'b11, 1'b1, 1'b1};
        else             return 6'b00_11_00;
    endfunction

    task automatic check_idle(input string tag, input int i);
        chk({tag, "_ctl"}, 32'(out_v[i]), 32'(6'b00_11_00));
        chk({tag, "_w1"}, 32'(w1_v[i]), 32'(prev1[i]));
        chk({tag, "_w2"}, 32'(w2_v[i]), 32'(prev2[i]));
    endtask

    // One full single-shot scan on instance i; optional extra start pulse
    // sampled at edge restart_at (0 = none).
    task automatic run_scan(input int i, input int s, input logic [3:0] a,
                            input logic [3:0] b, input int restart_at);
        int n = 4 * (s + 1);
        d1_v[i] = a;
        d2_v[i] = b;
        @(negedge clk) start_v[i] = 1'b1;
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clk);
            if (k == 1) start_v[i] = 1'b0;
            if (restart_at != 0 && k == restart_at - 1) start_v[i] = 1'b1;
            if (restart_at != 0 && k == restart_at) start_v[i] = 1'b0;
            chk($sformatf("ctl_i%0d_k%0d", i, k), 32'(out_v[i]), 32'(exp_scan(s, k, 1'b0)));
            chk($sformatf("w1_i%0d_k%0d", i, k), 32'(w1_v[i]), 32'(k <= n ? prev1[i] : a));
            chk($sformatf("w2_i%0d_k%0d", i, k), 32'(w2_v[i]), 32'(k <= n ? prev2[i] : b));
        end
        prev1[i] = a;
        prev2[i] = b;
    endtask

    // Scan on instance 0 (SETTLE=2) aborted by reset while select code 2 is out.
    task automatic abort_scan();
        d1_v[0] = 4'h3;
        d2_v[0] = 4'hC;
        @(negedge clk) start_v[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) start_v[0] = 1'b0;
            chk($sformatf("abort_ctl_k%0d", k), 32'(out_v[0]), 32'(exp_scan(2, k, 1'b0)));
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prev1[i] = 4'd0;
            prev2[i] = 4'd0;
        end
        #1;
        check_idle("abort_rst", 0);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check_idle($sformatf("abort_after_k%0d", k), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            d1_v[i]    = 4'd0;
            d2_v[i]    = 4'd0;
            prev1[i]   = 4'd0;
            prev2[i]   = 4'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle($sformatf("reset_i%0d", i), i);
        rst = 1'b0;
        @(negedge clk);
`ifdef MUX_SCAN_CONT_EN
        begin
            int n = 12;
            d1_v[0] = 4'h5;
            d2_v[0] = 4'h9;
            @(negedge clk) start_v[0] = 1'b1;
            for (int k = 1; k <= 3 * (n + 1) + 2; k++) begin
                int p;
                @(negedge clk);
                if (k == 1) start_v[0] = 1'b0;
                p = (k - 1) % (n + 1) + 1;
                chk($sformatf("cont_ctl_k%0d", k), 32'(out_v[0]), 32'(exp_scan(2, k, 1'b1)));
                chk($sformatf("cont_w1_k%0d", k), 32'(w1_v[0]),
                    32'((k <= n) ? 4'h0 : 4'h5));
                chk($sformatf("cont_w2_k%0d", k), 32'(w2_v[0]),
                    32'((k <= n) ? 4'h0 : 4'h9));
                if (p == 1) chk($sformatf("cont_busy_k%0d", k), 32'(out_v[0][1]), 32'd1);
            end
        end
`else
        run_scan(0, 2, 4'hA, 4'h6, 0);
        run_scan(1, 1, 4'hF, 4'h0, 0);
        run_scan(2, 255, 4'hF, 4'h0, 0);
        run_scan(0, 2, 4'(($urandom)), 4'(($urandom)), 5);
        run_scan(0, 2, 4'hA, 4'h6, 0);
        abort_scan();
        run_scan(0, 2, 4'hA, 4'h6, 0);
        run_scan(0, 2, 4'h1, 4'h8, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_idle($sformatf("hold_k%0d", k), 0);
        end
        run_scan(0, 2, 4'h8, 4'h1, 0);
        for (int r = 0; r < 8; r++) begin
            int i = int'($urandom_range(0, 1));
            run_scan(i, i == 0 ? 2 : 1, 4'($urandom), 4'($urandom), 0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
